f2c_dma_engine: RTL
===================

# f2c_dma_engine

Parametrised FPGA→CPU DMA engine: drains a 64-bit valid/ready data source into a CPU-side ring buffer of fixed-size posted-write TLPs. After each group of TLPs it posts a write-pointer metric TLP. It sits between the register decoder (base addresses, enable, CPU read pointer) and the 64-bit TX TLP arbiter of the transceiver. It generalises the fixed 16-slot, 16-QW sender: payload size, ring depth and metric-writeback interval are all configurable, and idle flushing of the metric is new.

## Interface
- `QW_PER_TLP`, 16, payload QWs per TLP; power of two, 1..64.
- `RING_NBITS`, 4, log2 of the number of ring slots; 1..8.
- `MTR_INTERVAL`, 1, data TLPs per metric writeback; 1..2**RING_NBITS-1.
- `clk_in` in 1: system clock; everything is on its rising edge.
- `reset_in` in 1: reset, synchronous and active-high.
- `cfgBusDev_in` in 13: our PCIe bus/device ID.
- `enable_in` in 1: DMA enable (the `DMA_ENABLE` register).
- `f2cBase_in` in 29: ring base, QW address.
- `mtrBase_in` in 29: metric base, QW address.
- `rdPtr_in` in RING_NBITS: CPU consumption pointer (`F2C_RDPTR`), level-sampled.
- `data_in` in 64: source data.
- `valid_in` in 1: source valid.
- `ready_out` out 1: source ready.
- `txData_out` out 64: TLP QW.
- `txValid_out` out 1: TLP QW valid.
- `txReady_in` in 1: TX accept.
- `txSOP_out` out 1: first QW of TLP.
- `txEOP_out` out 1: last QW of TLP.
- `wrPtr_out` out RING_NBITS: next slot to be written.
- `busy_out` out 1: state ≠ IDLE.

## Operation
- States: IDLE, DHDR0, DHDR1, DATA, MHDR0, MHDR1, MPTR, MPAD.
- The ring is full when `wrPtr+1 == rdPtr_in` (mod 2**RING_NBITS). At most 2**RING_NBITS−1 slots are outstanding.
- IDLE → DHDR0 when `enable_in && !full && valid_in`.
- IDLE → MHDR0 when `pending != 0` and no data TLP can start (disabled, full, or `!valid_in`). This is the flush: the CPU never waits on a stale pointer.
- DHDR0 emits `{3'b000, cfgBusDev_in, 8'h00, 8'hFF, 32'h4000_0000 | 2*QW_PER_TLP}` with SOP. For 16 QW this is 0x…00FF40000020.
- DHDR1 emits byte address `8*f2cBase_in + wrPtr*8*QW_PER_TLP`, zero-extended to 64 bits and computed without truncation.
- DATA is a combinational pass-through: `txData_out=data_in`, `txValid_out=valid_in`, `ready_out=txReady_in`.
  - A beat counter counts accepted beats. EOP is set on beat QW_PER_TLP−1.
  - Source gaps are allowed inside a TLP.
- On the accepted EOP beat:
  - `wrPtr` increments, wrapping.
  - `pending` increments.
  - If `pending+1 == MTR_INTERVAL`, go to MHDR0; else go to IDLE.
- Metric TLP, 4 QWs:
  - MHDR0: `{3'b000, cfgBusDev_in, 8'h00, 8'hFF, 32'h4000_0004}`, SOP.
  - MHDR1: `8*mtrBase_in`.
  - MPTR: `wrPtr`, zero-extended.
  - MPAD: 0, EOP.
  - On the MPAD accept, `pending` clears and the state goes to IDLE.
- `enable_in` falling mid-TLP: the current data TLP completes. Its metric then goes out via the flush path before IDLE is held.
- `f2cBase_in` and `mtrBase_in` are latched at DHDR0 and MHDR0 respectively. They are stable for the whole TLP.
- `ready_out` = 0 outside DATA.

## Timing
- Reset values:
  - State IDLE; `wrPtr`, `pending` and beat counter = 0.
  - `txValid_out`, `txSOP_out`, `txEOP_out`, `ready_out`, `busy_out` = 0.
  - `txData_out` = 0.
- Reset asserted mid-TLP: the TLP is abandoned and outputs take reset values the next cycle.
- A header or metric QW advances only on a cycle with `txValid_out && txReady_in`. `txData_out` is held while `txReady_in` is low.
- Back-to-back throughput with a continuous source and `txReady_in`=1:
  - QW_PER_TLP+2 cycles per data TLP, plus 4 per metric TLP.
  - One IDLE cycle between TLPs.
- `rdPtr_in` is sampled in IDLE only. A credit written in cycle N can start a TLP at N+1.
- Header fields are registered outputs. Only the DATA phase is combinational from `data_in`/`valid_in`/`txReady_in`.

## Structure
- Shared package `tlp_xcvr_pkg` holds:
  - `BusID`, `QWAddr`, `uint64`.
  - The `Header` and `Write0` formats, and the constants `FMT_WRITE64 = 8'h40` and `BE_ALL = 8'hFF`.
  - The state enum `F2CState`.
- Header and pointer arithmetic is inline. No sub-module is needed. `tlp_xcvr` instantiates this block in place of its fixed sender.

## Test plan
- **Default params, ring fill:** rng64 source, rdPtr=0, enable.
  - Expect exactly 15 data TLPs, addresses 8*base + t*128.
  - Each is followed by a metric with ptr=t+1. Then a stall with txValid=0.
- **Credit return:** from that stall, write rdPtr=1.
  - Expect TLP 15 at slot 15, then a metric with ptr=0 (wrap).
- **MTR_INTERVAL=4, QW_PER_TLP=8:** 8 data TLPs (header DW count 0x10).
  - Expect metrics only after TLPs 4 and 8, with ptr=4 and ptr=8.
  - Then stop the source after TLP 9: expect a flush metric with ptr=9.
- **Backpressure:** random `txReady_in`, 50% duty.
  - Every QW is held stable while not accepted.
  - The payload equals the rng SEQ64 sequence with no drops or duplicates.
- **Disable mid-TLP:** drop `enable_in` at data beat 5.
  - The remaining 11 beats complete, then the metric with ptr+1, then IDLE with busy=0.
- **Reset mid-TLP:** assert `reset_in` at beat 3.
  - Next cycle all outputs are 0 and `wrPtr_out`=0.
  - After release, the first header addresses slot 0.

Source files
------------

// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the TLP transceiver.
//   BusID / QWAddr / uint64 : PCIe requester ID, QW-granular address, 64-bit word
//   Header / Write0         : first and second QW of a 64-bit posted-write TLP
//   F2CState                : state of the FPGA->CPU DMA engine
package tlp_xcvr_pkg;

  typedef logic [12:0] BusID;
  typedef logic [28:0] QWAddr;
  typedef logic [63:0] uint64;

  localparam logic [7:0] FMT_WRITE64 = 8'h40;
  localparam logic [7:0] BE_ALL      = 8'hFF;

  // First QW of a posted write: requester, tag, byte enables, fmt/type and DW length.
  typedef struct packed {
    logic [2:0]  rsvd0;
    BusID        reqID;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [7:0]  fmtType;
    logic [13:0] rsvd1;
    logic [9:0]  dwCount;
  } Header;

  // Second QW of a 64-bit posted write: the byte address.
  typedef struct packed {
    logic [31:0] addrHi;
    logic [31:0] addrLo;
  } Write0;

  typedef enum logic [2:0] {
    IDLE,
    DHDR0,
    DHDR1,
    DATA,
    MHDR0,
    MHDR1,
    MPTR,
    MPAD
  } F2CState;

  function automatic Header mk_write_hdr(BusID id, logic [9:0] dw);
    Header h;
    h         = '0;
    h.reqID   = id;
    h.be      = BE_ALL;
    h.fmtType = FMT_WRITE64;
    h.dwCount = dw;
    return h;
  endfunction

endpackage

// File: rtl/f2c_dma_engine.sv
// FPGA->CPU DMA engine. Drains a 64-bit valid/ready source into a CPU ring of
// fixed-size posted-write TLPs and posts the write pointer to a metric slot
// after every MTR_INTERVAL data TLPs (or earlier, when the engine goes idle).
// Ports:
//   clk_in, reset_in          : clock, synchronous active-high reset
//   cfgBusDev_in              : our requester ID for TLP headers
//   enable_in                 : DMA enable
//   f2cBase_in, mtrBase_in    : ring / metric base, QW addresses
//   rdPtr_in                  : CPU consumption pointer (ring slot)
//   data_in/valid_in/ready_out: payload source
//   txData_out/txValid_out/txReady_in/txSOP_out/txEOP_out : TLP stream to arbiter
//   wrPtr_out                 : next ring slot to be written
//   busy_out                  : engine not idle
module f2c_dma_engine
  import tlp_xcvr_pkg::*;
#(
  parameter int QW_PER_TLP   = 16,
  parameter int RING_NBITS   = 4,
  parameter int MTR_INTERVAL = 1
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [12:0]           cfgBusDev_in,
  input  logic                  enable_in,
  input  logic [28:0]           f2cBase_in,
  input  logic [28:0]           mtrBase_in,
  input  logic [RING_NBITS-1:0] rdPtr_in,
  input  logic [63:0]           data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [63:0]           txData_out,
  output logic                  txValid_out,
  input  logic                  txReady_in,
  output logic                  txSOP_out,
  output logic                  txEOP_out,
  output logic [RING_NBITS-1:0] wrPtr_out,
  output logic                  busy_out
);

  localparam int         BEAT_W    = (QW_PER_TLP > 1) ? $clog2(QW_PER_TLP) : 1;
  localparam int         SLOT_SHFT = $clog2(QW_PER_TLP) + 3;
  localparam logic [9:0] DATA_DW   = 10'(2 * QW_PER_TLP);
  localparam logic [9:0] MTR_DW    = 10'd4;

  F2CState               state_q, state_d;
  logic [RING_NBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [RING_NBITS-1:0] pending_q, pending_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  QWAddr                 f2c_base_q, f2c_base_d;
  QWAddr                 mtr_base_q, mtr_base_d;
  uint64                 tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  tx_sop_q, tx_sop_d;
  logic                  tx_eop_q, tx_eop_d;

  logic full, can_start, hdr_accept, data_accept, beat_last, mtr_due;

  // Byte address of a ring slot, computed at 64 bits so a high base cannot wrap.
  function automatic uint64 slot_addr(QWAddr base, logic [RING_NBITS-1:0] slot);
    return (uint64'(base) << 3) + (uint64'(slot) << SLOT_SHFT);
  endfunction

  assign full        = (wr_ptr_q + RING_NBITS'(1)) == rdPtr_in;
  assign can_start   = enable_in && !full && valid_in;
  assign hdr_accept  = tx_valid_q && txReady_in;
  assign data_accept = valid_in && txReady_in;
  assign beat_last   = beat_q == BEAT_W'(QW_PER_TLP - 1);
  assign mtr_due     = (pending_q + RING_NBITS'(1)) == RING_NBITS'(MTR_INTERVAL);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    pending_d  = pending_q;
    beat_d     = beat_q;
    f2c_base_d = f2c_base_q;
    mtr_base_d = mtr_base_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;

    case (state_q)
      IDLE: begin
        if (can_start) begin
          state_d    = DHDR0;
          f2c_base_d = f2cBase_in;
          tx_data_d  = uint64'(mk_write_hdr(cfgBusDev_in, DATA_DW));
          tx_valid_d = 1'b1;
          tx_sop_d   = 1'b1;
          tx_eop_d   = 1'b0;
        end else if (pending_q != '0) begin
          // Flush: no data TLP can go, so publish the pointer now.
          state_d    = MHDR0;
          mtr_base_d = mtrBase_in;
          tx_data_d  = uint64'(mk_write_hdr(cfgBusDev_in, MTR_DW));
          tx_valid_d = 1'b1;
          tx_sop_d   = 1'b1;
          tx_eop_d   = 1'b0;
        end
      end
      DHDR0: begin
        if (hdr_accept) begin
          state_d   = DHDR1;
          tx_data_d = slot_addr(f2c_base_q, wr_ptr_q);
          tx_sop_d  = 1'b0;
        end
      end
      DHDR1: begin
        if (hdr_accept) begin
          state_d    = DATA;
          beat_d     = '0;
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
        end
      end
      DATA: begin
        if (data_accept) begin
          if (beat_last) begin
            beat_d    = '0;
            wr_ptr_d  = wr_ptr_q + RING_NBITS'(1);
            pending_d = pending_q + RING_NBITS'(1);
            if (mtr_due) begin
              state_d    = MHDR0;
              mtr_base_d = mtrBase_in;
              tx_data_d  = uint64'(mk_write_hdr(cfgBusDev_in, MTR_DW));
              tx_valid_d = 1'b1;
              tx_sop_d   = 1'b1;
              tx_eop_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      MHDR0: begin
        if (hdr_accept) begin
          state_d   = MHDR1;
          tx_data_d = uint64'(mtr_base_q) << 3;
          tx_sop_d  = 1'b0;
        end
      end
      MHDR1: begin
        if (hdr_accept) begin
          state_d   = MPTR;
          tx_data_d = uint64'(wr_ptr_q);
        end
      end
      MPTR: begin
        if (hdr_accept) begin
          state_d   = MPAD;
          tx_data_d = '0;
          tx_eop_d  = 1'b1;
        end
      end
      MPAD: begin
        if (hdr_accept) begin
          state_d    = IDLE;
          pending_d  = '0;
          tx_valid_d = 1'b0;
          tx_eop_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      pending_q  <= '0;
      beat_q     <= '0;
      f2c_base_q <= '0;
      mtr_base_q <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      pending_q  <= pending_d;
      beat_q     <= beat_d;
      f2c_base_q <= f2c_base_d;
      mtr_base_q <= mtr_base_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
    end
  end

  // Payload bypasses the output register so the source streams at full rate.
  always_comb begin
    if (state_q == DATA) begin
      txData_out  = data_in;
      txValid_out = valid_in;
      txSOP_out   = 1'b0;
      txEOP_out   = beat_last;
      ready_out   = txReady_in;
    end else begin
      txData_out  = tx_data_q;
      txValid_out = tx_valid_q;
      txSOP_out   = tx_sop_q;
      txEOP_out   = tx_eop_q;
      ready_out   = 1'b0;
    end
  end

  assign wrPtr_out = wr_ptr_q;
  assign busy_out  = state_q != IDLE;

endmodule
